// File: rtl/sync_fifo_param_if.sv
// Handshake bundle for sync_fifo_param: producer/consumer requests,
// read data and all status/error flags. master = user side, slave = FIFO.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    // requests from the user side
    logic              write_en;
    logic [DATA_W-1:0] data_in;
    logic              read_en;
    logic              err_clr;

    // results and status from the FIFO
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CW-1:0]     count;
    logic              overflow;
    logic              underflow;

    modport master (
        output write_en,
        output data_in,
        output read_en,
        output err_clr,
        input  data_out,
        input  data_valid,
        input  full,
        input  empty,
        input  almost_full,
        input  almost_empty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  write_en,
        input  data_in,
        input  read_en,
        input  err_clr,
        output data_out,
        output data_valid,
        output full,
        output empty,
        output almost_full,
        output almost_empty,
        output count,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with registered read data, fill level,
// almost-full/empty thresholds and sticky overflow/underflow flags.
// Ports: clk, rst (sync, active-low), bus (sync_fifo_param_if.slave):
//   write_en/data_in, read_en/data_out/data_valid, err_clr,
//   full, empty, almost_full, almost_empty, count, overflow, underflow.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                clk,
    input  logic                rst,
    sync_fifo_param_if.slave    bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic [CW-1:0]     r_wr_ptr;
    logic [CW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_data_valid;
    logic              r_full;
    logic              r_empty;
    logic              r_almost_full;
    logic              r_almost_empty;
    logic              r_overflow;
    logic              r_underflow;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic [CW-1:0]     w_count_nxt;
    logic [AW-1:0]     w_wr_idx;
    logic [AW-1:0]     w_rd_idx;

    // Acceptance is judged against the flags registered at cycle start,
    // so a read on an empty FIFO never bypasses a same-cycle write.
    assign w_wr_acc  = bus.write_en & ~r_full;
    assign w_rd_acc  = bus.read_en  & ~r_empty;
    assign w_ovf_set = bus.write_en &  r_full;
    assign w_unf_set = bus.read_en  &  r_empty;

    // The wrap bit is dropped for addressing; it only keeps the
    // pointer difference meaningful across a full lap.
    assign w_wr_idx = r_wr_ptr[AW-1:0];
    assign w_rd_idx = r_rd_ptr[AW-1:0];

    always_comb begin
        w_count_nxt = r_count;
        unique case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (rst && w_wr_acc) begin
            r_mem[w_wr_idx] <= bus.data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_data_out     <= '0;
            r_data_valid   <= 1'b0;
            r_full         <= 1'b0;
            r_empty        <= 1'b1;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + CW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr   <= r_rd_ptr + CW'(1);
                r_data_out <= r_mem[w_rd_idx];
            end
            r_data_valid <= w_rd_acc;

            // Flags follow the next count so they change on the same
            // edge as count itself.
            r_count        <= w_count_nxt;
            r_full         <= (w_count_nxt == CW'(DEPTH));
            r_empty        <= (w_count_nxt == '0);
            r_almost_full  <= (w_count_nxt >= CW'(AF_LEVEL));
            r_almost_empty <= (w_count_nxt <= CW'(AE_LEVEL));

            // A set event in the same cycle wins over err_clr.
            if (w_ovf_set) begin
                r_overflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_overflow <= 1'b0;
            end
            if (w_unf_set) begin
                r_underflow <= 1'b1;
            end else if (bus.err_clr) begin
                r_underflow <= 1'b0;
            end
        end
    end

    // Pointer distance must always equal the tracked fill level.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert ((r_wr_ptr - r_rd_ptr) == r_count)
            else $error("sync_fifo_param: pointer/count disagree");
        end
    end

    assign bus.data_out     = r_data_out;
    assign bus.data_valid   = r_data_valid;
    assign bus.full         = r_full;
    assign bus.empty        = r_empty;
    assign bus.almost_full  = r_almost_full;
    assign bus.almost_empty = r_almost_empty;
    assign bus.count        = r_count;
    assign bus.overflow     = r_overflow;
    assign bus.underflow    = r_underflow;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed bench for sync_fifo_param (DATA_W=8, DEPTH=16, AF=14, AE=2).
// Inputs change 1ns after posedge; outputs are checked at that point.
module tb_sync_fifo_param;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

    sync_fifo_param #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .AF_LEVEL (14),
        .AE_LEVEL (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_empty"}, 32'(bus.empty), 32'd1);
        chk({tag, "_full"}, 32'(bus.full), 32'd0);
        chk({tag, "_count"}, 32'(bus.count), 32'd0);
        chk({tag, "_valid"}, 32'(bus.data_valid), 32'd0);
        chk({tag, "_dout"}, 32'(bus.data_out), 32'h00);
        chk({tag, "_ae"}, 32'(bus.almost_empty), 32'd1);
        chk({tag, "_af"}, 32'(bus.almost_full), 32'd0);
        chk({tag, "_ovf"}, 32'(bus.overflow), 32'd0);
        chk({tag, "_unf"}, 32'(bus.underflow), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        bus.write_en = 1'b0;
        bus.data_in  = '0;
        bus.read_en  = 1'b0;
        bus.err_clr  = 1'b0;

        // 1: reset held 2 clocks while writing; write must be ignored
        bus.write_en = 1'b1;
        bus.data_in  = 8'h55;
        step();
        step();
        chk_reset_state("t1_rst");
        rst = 1'b1;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b1;
        step();
        chk("t1_unf", 32'(bus.underflow), 32'd1);
        chk("t1_valid", 32'(bus.data_valid), 32'd0);
        chk("t1_count", 32'(bus.count), 32'd0);
        bus.read_en = 1'b0;

        // 2: reset, fill 0x00..0x0F, then overflow attempt
        rst = 1'b0;
        step();
        chk("t2_unf_rst", 32'(bus.underflow), 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.write_en = 1'b1;
            bus.data_in  = 8'(i);
            step();
            chk("t2_count", 32'(bus.count), 32'(i + 1));
            chk("t2_af", 32'(bus.almost_full), 32'(i + 1 >= 14));
            chk("t2_full", 32'(bus.full), 32'(i + 1 == 16));
            chk("t2_ae", 32'(bus.almost_empty), 32'(i + 1 <= 2));
        end
        bus.data_in = 8'hAA;
        step();
        chk("t2_ovf", 32'(bus.overflow), 32'd1);
        chk("t2_cnt16", 32'(bus.count), 32'd16);
        chk("t2_full16", 32'(bus.full), 32'd1);
        bus.write_en = 1'b0;

        // 3: drain 16 words, order and 1-clock latency
        for (int i = 0; i < 16; i++) begin
            bus.read_en = 1'b1;
            step();
            chk("t3_dout", 32'(bus.data_out), 32'(i));
            chk("t3_valid", 32'(bus.data_valid), 32'd1);
            chk("t3_count", 32'(bus.count), 32'(15 - i));
        end
        chk("t3_empty", 32'(bus.empty), 32'd1);
        chk("t3_unf0", 32'(bus.underflow), 32'd0);
        step();
        chk("t3_unf", 32'(bus.underflow), 32'd1);
        chk("t3_hold", 32'(bus.data_out), 32'h0F);
        chk("t3_novalid", 32'(bus.data_valid), 32'd0);
        bus.read_en = 1'b0;
        bus.err_clr = 1'b1;
        step();
        chk("t3_clr_ovf", 32'(bus.overflow), 32'd0);
        chk("t3_clr_unf", 32'(bus.underflow), 32'd0);
        bus.err_clr = 1'b0;

        // 4: hold count at 5 with simultaneous read/write, 40 clocks
        for (int i = 0; i < 5; i++) begin
            bus.write_en = 1'b1;
            bus.data_in  = 8'(8'h10 + i);
            step();
        end
        chk("t4_cnt5", 32'(bus.count), 32'd5);
        bus.read_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            bus.data_in = 8'(8'h15 + i);
            step();
            chk("t4_dout", 32'(bus.data_out), 32'(8'h10 + i));
            chk("t4_count", 32'(bus.count), 32'd5);
            chk("t4_valid", 32'(bus.data_valid), 32'd1);
        end
        bus.read_en  = 1'b0;
        bus.write_en = 1'b0;

        // 5: fill to full (holds 0x38..0x3C), then read+write on full
        for (int i = 0; i < 11; i++) begin
            bus.write_en = 1'b1;
            bus.data_in  = 8'(8'h40 + i);
            step();
        end
        chk("t5_full", 32'(bus.full), 32'd1);
        bus.read_en = 1'b1;
        bus.data_in = 8'hEE;
        step();
        chk("t5_count", 32'(bus.count), 32'd15);
        chk("t5_ovf", 32'(bus.overflow), 32'd1);
        chk("t5_dout", 32'(bus.data_out), 32'h38);
        chk("t5_nfull", 32'(bus.full), 32'd0);
        bus.read_en  = 1'b0;
        bus.write_en = 1'b0;
        bus.err_clr  = 1'b1;
        step();
        chk("t5_clr", 32'(bus.overflow), 32'd0);
        bus.err_clr = 1'b0;

        // 6: set beats clear; then reset mid-fill at count 7
        bus.write_en = 1'b1;
        bus.data_in  = 8'h50;
        step();
        chk("t6_full", 32'(bus.full), 32'd1);
        bus.err_clr = 1'b1;
        step();
        chk("t6_ovf_win", 32'(bus.overflow), 32'd1);
        chk("t6_cnt16", 32'(bus.count), 32'd16);
        bus.err_clr  = 1'b0;
        bus.write_en = 1'b0;
        bus.read_en  = 1'b1;
        for (int i = 0; i < 9; i++) begin
            step();
        end
        bus.read_en = 1'b0;
        chk("t6_cnt7", 32'(bus.count), 32'd7);
        chk("t6_dout", 32'(bus.data_out), 32'h44);
        chk("t6_ovf7", 32'(bus.overflow), 32'd1);
        rst = 1'b0;
        bus.write_en = 1'b1;
        bus.data_in  = 8'h77;
        step();
        chk_reset_state("t6_rst");
        rst = 1'b1;
        bus.write_en = 1'b0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end
endmodule
